// File: rtl/count_extender_if.sv
// Handshake bundle for count_extender: sample input side and record output side.
// The slave modport is the extender; the master modport is its environment.
interface count_extender_if #(
   parameter int IN_W    = 4,
   parameter int EPOCH_W = 8
);
   logic                    in_valid;
   logic [IN_W-1:0]         in_data;
   logic                    in_ready;
   logic                    out_valid;
   logic                    out_ready;
   logic [IN_W+EPOCH_W-1:0] out_count;
   logic [IN_W-1:0]         out_delta;
   logic                    out_wrap;
   logic                    out_gap;
   logic                    sat;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_count,
      input  out_delta, out_wrap, out_gap, sat
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_count,
      output out_delta, out_wrap, out_gap, sat
   );
endinterface

// File: rtl/count_extender.sv
// Widens a narrow wrap-around counter into a monotonic count with an epoch
// counter, flagging wraps, skips and repeats through a registered output.
module count_extender #(
   parameter int IN_W        = 4,
   parameter int EPOCH_W     = 8,
   parameter int EXPECT_STEP = 1
) (
   input  logic       clk,
   input  logic       rst,
   count_extender_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] SAT  = 2'd2;

   localparam logic [EPOCH_W-1:0] EPOCH_MAX = '1;
   localparam logic [IN_W-1:0]    STEP      = IN_W'(EXPECT_STEP);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [IN_W-1:0]    prev;
   logic [IN_W-1:0]    delta;
   logic [EPOCH_W-1:0] epoch;
   logic [EPOCH_W-1:0] epoch_nxt;
   logic               wrap;
   logic               gap;
   logic               sat_nxt;
   logic               accept;

   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   // The record carries the already-updated epoch so it never lags.
   always_comb begin
      state_nxt = state;
      delta     = '0;
      wrap      = 1'b0;
      gap       = 1'b0;
      epoch_nxt = epoch;
      sat_nxt   = bus.sat;
      unique case (1'b1)
         (state == IDLE): begin
            state_nxt = RUN;
         end
         (state == RUN),
         (state == SAT): begin
            delta = bus.in_data - prev;
            wrap  = bus.in_data < prev;
            gap   = delta != STEP;
            if (wrap) begin
               if (epoch != EPOCH_MAX) begin
                  epoch_nxt = epoch + 1'b1;
               end else begin
                  sat_nxt   = 1'b1;
                  state_nxt = SAT;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         prev          <= '0;
         epoch         <= '0;
         bus.out_valid <= 1'b0;
         bus.out_count <= '0;
         bus.out_delta <= '0;
         bus.out_wrap  <= 1'b0;
         bus.out_gap   <= 1'b0;
         bus.sat       <= 1'b0;
      end else if (accept) begin
         state         <= state_nxt;
         prev          <= bus.in_data;
         epoch         <= epoch_nxt;
         bus.out_valid <= 1'b1;
         bus.out_count <= {epoch_nxt, bus.in_data};
         bus.out_delta <= delta;
         bus.out_wrap  <= wrap;
         bus.out_gap   <= gap;
         bus.sat       <= sat_nxt;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: doc/count_extender.md
# count_extender

Downstream stage for a narrow free-running wrap-around counter, such as the team's 4-bit overflowing register. It samples the narrow count through a valid/ready handshake and detects each wrap-around. It keeps an epoch counter so it can emit a widened monotonic count, and it flags skipped or repeated samples. The output is registered with back-pressure, so the block can feed logging or monitor logic that may stall.

## Interface
- IN_W, 4, width of the narrow upstream counter.
- EPOCH_W, 8, width of the epoch (wrap) counter; the extended count is IN_W+EPOCH_W bits.
- EXPECT_STEP, 1, expected modular increment between consecutive accepted samples (1 ≤ EXPECT_STEP < 2^IN_W).

- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream sample present.
- in_data  in  IN_W  narrow counter value.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  output record present.
- out_ready  in  1  downstream accepts the record.
- out_count  out  IN_W+EPOCH_W  {epoch, in_data} extended count.
- out_delta  out  IN_W  (in_data − previous sample) mod 2^IN_W.
- out_wrap  out  1  this sample crossed a wrap boundary.
- out_gap  out  1  out_delta ≠ EXPECT_STEP.
- sat  out  1  sticky: the epoch counter has saturated.

## Operation
- The state machine has three states: IDLE (no sample since reset), RUN and SAT.
- A sample is accepted on any edge where in_valid && in_ready.
- IDLE, first accepted sample:
  - prev ← in_data; epoch stays 0.
  - Record is {0, in_data}, delta 0, wrap 0, gap 0.
  - Next state is RUN.
- RUN, accepted sample:
  - delta = in_data − prev, truncated to IN_W bits.
  - wrap = (in_data < prev), unsigned compare.
  - gap = (delta ≠ EXPECT_STEP).
  - prev ← in_data.
  - If wrap and epoch < 2^EPOCH_W−1: epoch ← epoch+1, and the record uses the incremented epoch.
  - If wrap and epoch == 2^EPOCH_W−1: epoch holds, sat ← 1, next state is SAT.
- A repeated value (delta 0) gives wrap 0 and gap 1.
- A forward jump across the boundary (e.g. 14→2) gives wrap 1 and delta 4; gap is 1 if 4 ≠ EXPECT_STEP.
- SAT:
  - Behaves as RUN, but epoch is frozen at all-ones and wrap still pulses per record.
  - sat stays 1 until rst.
- Output register: a single entry. in_ready = !out_valid || out_ready.
  - While out_valid && !out_ready, all out_* signals are held stable.
- Reset:
  - out_valid 0, out_count 0, out_delta 0, out_wrap 0, out_gap 0, sat 0.
  - epoch 0, prev 0, state IDLE.
  - in_ready is 1 in the first cycle after reset is released.
  - Reset asserted mid-stream discards any pending record. The next sample is treated as the first.

## Timing
- Latency is 1 cycle: a sample accepted at edge k gives out_valid=1 with its record after edge k.
- Throughput is 1 record per cycle when out_ready is held high. A consume and an accept on the same edge replace the record with no bubble.
- out_valid falls at the edge where the record is consumed, provided no new sample is accepted on that edge.
- The wrap, gap and epoch update are all computed combinationally from in_data and prev, then registered at the accept edge. The epoch never lags the record it labels.
- rst has priority over an accept on the same edge.
- No combinational path from out_ready to out_*. in_ready depends combinationally on out_ready only.

## Test plan
- Free-run: feed 0..15 then 0..3 with in_valid=1 and out_ready=1.
  - Required: out_count 0..19 consecutively, one cycle after each input.
  - out_wrap=1 only on the record whose in_data=0 after 15 (out_count 16); out_gap always 0.
- Skip and repeat: feed 3, 6, 6.
  - Required: records are delta 0/gap 0, then delta 3/gap 1, then delta 0/gap 1; wrap is 0 on all three.
- Wrap with gap: feed 14, 2.
  - Required: second record has delta 4, wrap 1, gap 1, out_count 18.
- Back-pressure: hold out_ready=0 for 3 cycles with in_valid=1 and data 5, 6, 7.
  - Required: in_ready=0 while the record for 5 is held, and out_count stays at 5.
  - After release, 5, 6, 7 emerge in order with none lost or duplicated.
- Saturation (EPOCH_W=2): drive 4 full wraps.
  - Required: epoch goes 1, 2, 3 and then stays 3.
  - sat=1 from the 4th wrap's record onward; out_count upper bits stay 3; wrap still pulses.
- Mid-stream reset: assert rst for 1 cycle while out_valid=1 and epoch=2.
  - Required: next cycle has out_valid=0 and sat=0.
  - The following sample 9 emits out_count 9 with delta 0, wrap 0 and gap 0.
